// File: rtl/aesha_pkg.sv
// Shared AES constants, types and GF(2^8) helpers for the AESHA key schedule and cipher datapath.
// The KS_BUSY state exists only when AESHA_KEY_SBOX_PIPE_EN is defined.
package aesha_pkg;

  localparam int AES_KEY_W  = 128;
  localparam int AES_ROUNDS = 10;

  typedef logic [31:0]          aes_word_t;
  typedef logic [AES_KEY_W-1:0] aes_key_t;

  // Indexed by the low nibble of the round number; only entries 1..10 are ever used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {
    KS_IDLE  = 2'd0,
    KS_ARMED = 2'd1,
`ifdef AESHA_KEY_SBOX_PIPE_EN
    KS_BUSY  = 2'd2,
`endif
    KS_DONE  = 2'd3
  } ks_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic aes_key_t key_expand(input aes_key_t k, input aes_word_t sub_rot,
                                          input logic [7:0] rcon);
    aes_word_t w0;
    aes_word_t w1;
    aes_word_t w2;
    aes_word_t w3;
    w0 = k[127:96] ^ sub_rot ^ {rcon, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Round-counter / datapath side of the AES-128 key schedule.
// master drives round pulses and key loads; slave is the key schedule itself.
interface aes_key_schedule_if #(
  parameter int KEY_W   = 128,
  parameter int ROUND_W = 5
);
  logic               i_key_load;
  logic [KEY_W-1:0]   i_key;
  logic [ROUND_W-1:0] i_round;
  logic               i_round_valid;
  logic [KEY_W-1:0]   o_round_key;
  logic [ROUND_W-1:0] o_round_idx;
  logic               o_key_valid;
  logic               o_last;
  logic               o_seq_err;

  modport master (
    output i_key_load, i_key, i_round, i_round_valid,
    input  o_round_key, o_round_idx, o_key_valid, o_last, o_seq_err
  );

  modport slave (
    input  i_key_load, i_key, i_round, i_round_valid,
    output o_round_key, o_round_idx, o_key_valid, o_last, o_seq_err
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
  import aesha_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);
  logic [7:0] inv;

  assign inv    = gf_inv(value);
  assign result = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: rtl/aes_key_schedule.sv
// On-the-fly AES-128 round-key generator driven by the AES round counter.
// Define AESHA_KEY_SBOX_PIPE_EN to register SubWord(RotWord(w3)) and add a BUSY cycle per round.
module aes_key_schedule
  import aesha_pkg::*;
#(
  parameter int KEY_W      = AES_KEY_W,
  parameter int ROUND_W    = 5,
  parameter int NUM_ROUNDS = AES_ROUNDS
) (
  input  logic              i_clk,
  input  logic              i_reset,
  aes_key_schedule_if.slave bus
);
  ks_state_t          state;
  logic [KEY_W-1:0]   key_q;
  logic [ROUND_W-1:0] idx_q;
  logic               kv_q;
  logic               last_q;
  logic               err_q;
  aes_word_t          rot;
  aes_word_t          sub;
  logic               round_ok;

  assign rot = {key_q[23:0], key_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (.value(rot[8*i +: 8]), .result(sub[8*i +: 8]));
  end

  assign round_ok = (state == KS_ARMED)
                 && (bus.i_round == idx_q + ROUND_W'(1))
                 && (bus.i_round <= ROUND_W'(NUM_ROUNDS));

`ifdef AESHA_KEY_SBOX_PIPE_EN
  aes_word_t          sub_q;
  logic [ROUND_W-1:0] pend_q;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= KS_IDLE;
      key_q  <= '0;
      idx_q  <= '0;
      kv_q   <= 1'b0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef AESHA_KEY_SBOX_PIPE_EN
      sub_q  <= '0;
      pend_q <= '0;
`endif
    end else begin
      kv_q <= 1'b0;
      // A load wins over everything, including a pending pipelined update.
      if (bus.i_key_load) begin
        key_q  <= bus.i_key;
        idx_q  <= '0;
        kv_q   <= 1'b1;
        last_q <= 1'b0;
        err_q  <= 1'b0;
        state  <= KS_ARMED;
      end else begin
`ifdef AESHA_KEY_SBOX_PIPE_EN
        if (state == KS_BUSY) begin
          key_q <= key_expand(key_q, sub_q, RCON[pend_q[3:0]]);
          idx_q <= pend_q;
          kv_q  <= 1'b1;
          if (pend_q == ROUND_W'(NUM_ROUNDS)) begin
            last_q <= 1'b1;
            state  <= KS_DONE;
          end else begin
            state <= KS_ARMED;
          end
          if (bus.i_round_valid) err_q <= 1'b1;
        end else
`endif
        if (bus.i_round_valid) begin
          if (round_ok) begin
`ifdef AESHA_KEY_SBOX_PIPE_EN
            sub_q  <= sub;
            pend_q <= bus.i_round;
            state  <= KS_BUSY;
`else
            key_q <= key_expand(key_q, sub, RCON[bus.i_round[3:0]]);
            idx_q <= bus.i_round;
            kv_q  <= 1'b1;
            if (bus.i_round == ROUND_W'(NUM_ROUNDS)) begin
              last_q <= 1'b1;
              state  <= KS_DONE;
            end
`endif
          end else begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_round_key = key_q;
  assign bus.o_round_idx = idx_q;
  assign bus.o_key_valid = kv_q;
  assign bus.o_last      = last_q;
  assign bus.o_seq_err   = err_q;
endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule using the FIPS-197 AES-128 example key schedule.
// Honours AESHA_KEY_SBOX_PIPE_EN for the two-cycle key latency.
module tb_aes_key_schedule;

  localparam logic [127:0] RK [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   kv_count = 0;
  int   n0;

  aes_key_schedule_if bus_if ();

  aes_key_schedule dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_if.o_key_valid === 1'b1) kv_count++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    bus_if.i_key_load = 1'b1;
    bus_if.i_key      = k;
    @(negedge clk);
    bus_if.i_key_load = 1'b0;
    bus_if.i_key      = '0;
  endtask

  task automatic pulse_round(input int r);
    @(negedge clk);
    bus_if.i_round_valid = 1'b1;
    bus_if.i_round       = r[4:0];
    @(negedge clk);
    bus_if.i_round_valid = 1'b0;
    bus_if.i_round       = '0;
  endtask

  task automatic round_step(input int r);
    pulse_round(r);
`ifdef AESHA_KEY_SBOX_PIPE_EN
    chk("pipe_kv_low", 128'(bus_if.o_key_valid), 128'(0));
    chk("pipe_key_held", bus_if.o_round_key, RK[r-1]);
    @(negedge clk);
`endif
    chk($sformatf("key_r%0d", r), bus_if.o_round_key, RK[r]);
    chk($sformatf("idx_r%0d", r), 128'(bus_if.o_round_idx), 128'(r));
    chk($sformatf("kv_r%0d", r), 128'(bus_if.o_key_valid), 128'(1));
    chk($sformatf("last_r%0d", r), 128'(bus_if.o_last), 128'(r == 10));
  endtask

  initial begin
    bus_if.i_key_load    = 1'b0;
    bus_if.i_key         = '0;
    bus_if.i_round       = '0;
    bus_if.i_round_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_key", bus_if.o_round_key, 128'(0));
    chk("rst_idx", 128'(bus_if.o_round_idx), 128'(0));
    chk("rst_kv", 128'(bus_if.o_key_valid), 128'(0));
    chk("rst_last", 128'(bus_if.o_last), 128'(0));
    chk("rst_err", 128'(bus_if.o_seq_err), 128'(0));
    rst = 1'b0;

    pulse_round(1);
    chk("idle_err", 128'(bus_if.o_seq_err), 128'(1));
    chk("idle_key", bus_if.o_round_key, 128'(0));

    load_key(RK[0]);
    chk("load_key", bus_if.o_round_key, RK[0]);
    chk("load_idx", 128'(bus_if.o_round_idx), 128'(0));
    chk("load_kv", 128'(bus_if.o_key_valid), 128'(1));
    chk("load_err_clr", 128'(bus_if.o_seq_err), 128'(0));

    round_step(1);
    @(negedge clk);
    chk("kv_single", 128'(bus_if.o_key_valid), 128'(0));

    pulse_round(3);
    @(negedge clk);
    chk("skip_err", 128'(bus_if.o_seq_err), 128'(1));
    chk("skip_key", bus_if.o_round_key, RK[1]);
    chk("skip_idx", 128'(bus_if.o_round_idx), 128'(1));

    load_key(RK[0]);
    chk("reload_err", 128'(bus_if.o_seq_err), 128'(0));
    chk("reload_idx", 128'(bus_if.o_round_idx), 128'(0));

    @(negedge clk);
    bus_if.i_key_load    = 1'b1;
    bus_if.i_key         = RK[0];
    bus_if.i_round_valid = 1'b1;
    bus_if.i_round       = 5'd1;
    @(negedge clk);
    bus_if.i_key_load    = 1'b0;
    bus_if.i_round_valid = 1'b0;
    bus_if.i_round       = '0;
    chk("coll_idx", 128'(bus_if.o_round_idx), 128'(0));
    chk("coll_err", 128'(bus_if.o_seq_err), 128'(0));
    chk("coll_key", bus_if.o_round_key, RK[0]);
    repeat (2) @(negedge clk);
    chk("coll_idx_hold", 128'(bus_if.o_round_idx), 128'(0));
    chk("coll_kv_low", 128'(bus_if.o_key_valid), 128'(0));

    pulse_round(0);
    @(negedge clk);
    chk("r0_err", 128'(bus_if.o_seq_err), 128'(1));
    chk("r0_idx", 128'(bus_if.o_round_idx), 128'(0));

    @(negedge clk);
    #1 n0 = kv_count;
    load_key(RK[0]);
    chk("full_err_clr", 128'(bus_if.o_seq_err), 128'(0));
    for (int r = 1; r <= 10; r++) round_step(r);
    @(negedge clk);
    #1 chk("kv_pulses", 128'(kv_count - n0), 128'(11));
    chk("done_last", 128'(bus_if.o_last), 128'(1));
    pulse_round(11);
    chk("done_err", 128'(bus_if.o_seq_err), 128'(1));
    chk("done_key", bus_if.o_round_key, RK[10]);

    load_key(RK[0]);
    for (int r = 1; r <= 5; r++) round_step(r);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_key", bus_if.o_round_key, 128'(0));
    chk("arst_idx", 128'(bus_if.o_round_idx), 128'(0));
    chk("arst_kv", 128'(bus_if.o_key_valid), 128'(0));
    chk("arst_last", 128'(bus_if.o_last), 128'(0));
    chk("arst_err", 128'(bus_if.o_seq_err), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    load_key(RK[0]);
    for (int r = 1; r <= 10; r++) round_step(r);
    chk("rerun_key", bus_if.o_round_key, RK[10]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
